// File: rtl/match_pkg.sv
// rtl/match_pkg.sv - shared widths and sequencer state type for the matcher
package match_pkg;
   localparam int IDX_W  = 10;
   localparam int HD_W   = 8;
   localparam int COOR_W = 20;
   localparam int DES_W  = 128;
   localparam int FEAT_W = 148;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_SWEEP,
      S_WAIT,
      S_EMIT,
      S_FIN
   } sched_state_t;
endpackage

// File: rtl/match_delay_line.sv
// rtl/match_delay_line.sv - 1-bit shift register with synchronous clear
module match_delay_line #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic clear,
   input  logic din,
   output logic dout
);
   generate
      if (DEPTH == 0) begin : g_pass
         logic unused_pass;
         assign unused_pass = clk ^ clear;
         assign dout = din;
      end else begin : g_pipe
         logic [DEPTH-1:0] taps;
         always_ff @(posedge clk) begin
            if (clear) begin
               taps <= '0;
            end else begin
               taps[0] <= din;
               for (int i = 1; i < DEPTH; i++) begin
                  taps[i] <= taps[i-1];
               end
            end
         end
         assign dout = taps[DEPTH-1];
      end
   endgenerate
endmodule

// File: rtl/match_sched.sv
// rtl/match_sched.sv - sweeps every slave feature per main feature through match_core
// and emits thresholded best-match records on a valid/ready port.
module match_sched
   import match_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              start,
   input  logic [IDX_W-1:0]  num_main,
   input  logic [IDX_W-1:0]  num_slave,
   input  logic [HD_W-1:0]   hd_thresh,
   output logic              main_rd,
   output logic [IDX_W-1:0]  main_addr,
   output logic              slave_rd,
   output logic [IDX_W-1:0]  slave_addr,
   output logic              core_clear,
   output logic              core_en,
   input  logic              core_done,
   input  logic [IDX_W-1:0]  core_index,
   input  logic [COOR_W-1:0] core_coor,
   input  logic [HD_W-1:0]   core_min_hd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_main_idx,
   output logic [IDX_W-1:0]  out_slave_idx,
   output logic [COOR_W-1:0] out_coor,
   output logic [HD_W-1:0]   out_hd,
   output logic              busy,
   output logic              done,
   output logic [IDX_W-1:0]  match_count
);
   sched_state_t state, state_nx;

   logic [IDX_W-1:0] m, s, n_main, n_slave;
   logic [HD_W-1:0]  thresh;
   logic             last_main, last_slave, accept;

   assign last_main  = (m == n_main - IDX_W'(1));
   assign last_slave = (s == n_slave - IDX_W'(1));
   assign accept     = core_done && (core_min_hd <= thresh);

   always_ff @(posedge clk) begin
      if (clear) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      main_rd    = 1'b0;
      slave_rd   = 1'b0;
      core_clear = 1'b0;
      done       = 1'b0;
      busy       = 1'b1;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_nx = (num_main == '0) ? S_FIN : S_CLR;
         end
         S_CLR: begin
            core_clear = 1'b1;
            main_rd    = 1'b1;
            if (n_slave == '0) state_nx = last_main ? S_FIN : S_CLR;
            else               state_nx = S_SWEEP;
         end
         S_SWEEP: begin
            slave_rd = 1'b1;
            if (last_slave) state_nx = S_WAIT;
         end
         S_WAIT: begin
            if (core_done) begin
               if (accept)         state_nx = S_EMIT;
               else if (last_main) state_nx = S_FIN;
               else                state_nx = S_CLR;
            end
         end
         S_EMIT: begin
            if (out_ready) state_nx = last_main ? S_FIN : S_CLR;
         end
         S_FIN: begin
            busy     = 1'b0;
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: begin
            busy     = 1'b0;
            state_nx = S_IDLE;
         end
      endcase
   end

   // Run parameters, sweep counters and the pending output record.
   always_ff @(posedge clk) begin
      if (clear) begin
         m             <= '0;
         s             <= '0;
         n_main        <= '0;
         n_slave       <= '0;
         thresh        <= '0;
         out_valid     <= 1'b0;
         out_main_idx  <= '0;
         out_slave_idx <= '0;
         out_coor      <= '0;
         out_hd        <= '0;
         match_count   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  n_main      <= num_main;
                  n_slave     <= num_slave;
                  thresh      <= hd_thresh;
                  m           <= '0;
                  match_count <= '0;
               end
            end
            S_CLR: begin
               s <= '0;
               if (n_slave == '0 && !last_main) m <= m + IDX_W'(1);
            end
            S_SWEEP: begin
               s <= s + IDX_W'(1);
            end
            S_WAIT: begin
               if (accept) begin
                  out_valid     <= 1'b1;
                  out_main_idx  <= m;
                  out_slave_idx <= core_index;
                  out_coor      <= core_coor;
                  out_hd        <= core_min_hd;
               end else if (core_done && !last_main) begin
                  m <= m + IDX_W'(1);
               end
            end
            S_EMIT: begin
               if (out_ready) begin
                  out_valid   <= 1'b0;
                  match_count <= match_count + IDX_W'(1);
                  if (!last_main) m <= m + IDX_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign main_addr  = main_rd  ? m : '0;
   assign slave_addr = slave_rd ? s : '0;

   // Aligns core_en with the slave RAM read data.
   match_delay_line #(
      .DEPTH (RD_LAT)
   ) u_en_pipe (
      .clk   (clk),
      .clear (clear),
      .din   (slave_rd),
      .dout  (core_en)
   );
endmodule

// File: tb/tb_match_sched.sv
// tb/tb_match_sched.sv - self-checking bench for match_sched with RAM and core stand-ins
module tb_match_sched;
   import match_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              clear = 1'b1;
   logic              start = 1'b0;
   logic [IDX_W-1:0]  num_main = '0;
   logic [IDX_W-1:0]  num_slave = '0;
   logic [HD_W-1:0]   hd_thresh = '0;
   logic              main_rd, slave_rd, core_clear, core_en;
   logic [IDX_W-1:0]  main_addr, slave_addr;
   logic              core_done = 1'b0;
   logic [IDX_W-1:0]  core_index = '0;
   logic [COOR_W-1:0] core_coor = '0;
   logic [HD_W-1:0]   core_min_hd = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [IDX_W-1:0]  out_main_idx, out_slave_idx, match_count;
   logic [COOR_W-1:0] out_coor;
   logic [HD_W-1:0]   out_hd;
   logic              busy, done;

   match_sched #(.RD_LAT(1)) dut (
      .clk(clk), .clear(clear), .start(start),
      .num_main(num_main), .num_slave(num_slave), .hd_thresh(hd_thresh),
      .main_rd(main_rd), .main_addr(main_addr),
      .slave_rd(slave_rd), .slave_addr(slave_addr),
      .core_clear(core_clear), .core_en(core_en), .core_done(core_done),
      .core_index(core_index), .core_coor(core_coor), .core_min_hd(core_min_hd),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_main_idx(out_main_idx), .out_slave_idx(out_slave_idx),
      .out_coor(out_coor), .out_hd(out_hd),
      .busy(busy), .done(done), .match_count(match_count)
   );

   logic [HD_W-1:0] hd_tbl [0:3][0:7];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Feature RAMs (1-cycle sync read) and a behavioural match_core.
   logic [IDX_W-1:0] ram_sidx = '0, ram_midx = '0;
   int  en_cnt = 0, done_dly = 0;
   logic en_q = 1'b0, have = 1'b0;

   always @(posedge clk) begin
      if (main_rd)  ram_midx <= main_addr;
      if (slave_rd) ram_sidx <= slave_addr;
   end

   always @(posedge clk) begin
      core_done <= 1'b0;
      if (clear || core_clear) begin
         have <= 1'b0; en_q <= 1'b0; done_dly <= 0; en_cnt <= 0;
         core_index <= '0; core_coor <= '0; core_min_hd <= '0;
      end else begin
         en_q <= core_en;
         if (core_en) begin
            en_cnt <= en_cnt + 1;
            if (!have || hd_tbl[ram_midx[1:0]][ram_sidx[2:0]] < core_min_hd) begin
               have        <= 1'b1;
               core_min_hd <= hd_tbl[ram_midx[1:0]][ram_sidx[2:0]];
               core_index  <= ram_sidx;
               core_coor   <= COOR_W'(32'hA0000 + 32'(ram_sidx));
            end
         end
         if (en_q && !core_en) done_dly <= 3;
         else if (done_dly == 1) begin done_dly <= 0; core_done <= 1'b1; end
         else if (done_dly > 1) done_dly <= done_dly - 1;
      end
   end

   // Expected records derived directly from the matching rules.
   typedef struct { int m; int s; int coor; int hd; } rec_t;
   rec_t exp_q[$];
   int   exp_total = 0;

   task automatic build_expect(input int nm, input int ns, input int th);
      rec_t r;
      exp_q.delete();
      exp_total = 0;
      for (int mi = 0; mi < nm; mi++) begin
         if (ns > 0) begin
            int best = 0;
            for (int si = 1; si < ns; si++)
               if (hd_tbl[mi][si] < hd_tbl[mi][best]) best = si;
            if (int'(hd_tbl[mi][best]) <= th) begin
               r.m = mi; r.s = best; r.coor = 'hA0000 + best; r.hd = int'(hd_tbl[mi][best]);
               exp_q.push_back(r);
               exp_total++;
            end
         end
      end
   endtask

   int stall_left = 0;
   always @(posedge clk) begin
      #1;
      if (out_valid && stall_left > 0) stall_left--;
      out_ready = (stall_left == 0);
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   done_seen = 0, done_cyc = 0, clr_pulses = 0, en_total = 0, stall_cycles = 0, sweep_ns = 0;
   int   last_m = -1, last_s = -1, last_coor = -1, last_hd = -1;
   logic prev_valid = 1'b0, prev_ready = 1'b0;
   logic [47:0] prev_bundle = '0;
   rec_t rec;

   always @(negedge clk) begin
      if (clear) begin
         prev_valid = 1'b0;
      end else begin
         if (prev_valid && !prev_ready) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_fields", {out_main_idx, out_slave_idx, out_coor, out_hd}, prev_bundle);
         end
         if (out_valid) chk("no_strobes_while_pending", {main_rd, slave_rd, core_en}, 0);
         if (out_valid && !out_ready) stall_cycles++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_record", 1, 0);
            end else begin
               rec = exp_q.pop_front();
               chk("rec_main_idx", out_main_idx, rec.m);
               chk("rec_slave_idx", out_slave_idx, rec.s);
               chk("rec_coor", out_coor, rec.coor);
               chk("rec_hd", out_hd, rec.hd);
               last_m = int'(out_main_idx); last_s = int'(out_slave_idx);
               last_coor = int'(out_coor); last_hd = int'(out_hd);
            end
         end
         if (core_clear) clr_pulses++;
         if (core_en) en_total++;
         if (core_done) chk("core_en_burst_len", en_cnt, sweep_ns);
         if (done) begin
            chk("match_count_at_done", match_count, exp_total);
            chk("records_drained", exp_q.size(), 0);
            chk("busy_low_at_done", busy, 0);
            done_seen++;
            done_cyc = cyc;
         end
         prev_valid  = out_valid;
         prev_ready  = out_ready;
         prev_bundle = {out_main_idx, out_slave_idx, out_coor, out_hd};
      end
   end

   task automatic run(input int nm, input int ns, input int th, input int stall, input bit dup);
      int target, start_cyc, waited;
      build_expect(nm, ns, th);
      sweep_ns = ns; clr_pulses = 0; en_total = 0; stall_cycles = 0;
      target = done_seen + 1;
      @(posedge clk); #1;
      stall_left = stall;
      start = 1'b1; num_main = IDX_W'(nm); num_slave = IDX_W'(ns); hd_thresh = HD_W'(th);
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      if (dup) begin
         repeat (5) @(posedge clk);
         #1;
         start = 1'b1; num_main = 1; num_slave = 1; hd_thresh = 0;
         @(posedge clk); #1;
         start = 1'b0;
      end
      waited = 0;
      while (done_seen < target && waited < 3000) begin
         @(posedge clk);
         waited++;
      end
      chk("run_finished", done_seen >= target, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("single_done_pulse", done_seen, target);
      chk("core_clear_pulses", clr_pulses, nm);
      if (nm == 0) chk("empty_run_done_latency", done_cyc - start_cyc, 1);
   endtask

   initial begin
      int waited;
      hd_tbl[0] = '{30, 12, 12, 40, 50, 50, 50, 50};
      hd_tbl[1] = '{25, 30, 40, 60, 99, 99, 99, 99};
      hd_tbl[2] = '{ 9,  7,  8,  7, 99, 99, 99, 99};
      hd_tbl[3] = '{100, 90, 80, 70, 60, 55, 55, 99};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_strobes", {main_rd, slave_rd, core_clear, core_en, out_valid, busy, done}, 0);
      chk("reset_addrs", {main_addr, slave_addr, match_count}, 0);
      chk("reset_record", {out_main_idx, out_slave_idx, out_coor, out_hd}, 0);
      clear = 1'b0;

      run(1, 4, 20, 0, 0);
      chk("t1_slave_idx", last_s, 1);
      chk("t1_hd", last_hd, 12);
      chk("t1_coor", last_coor, 'hA0001);
      chk("t1_main_idx", last_m, 0);
      chk("t1_count", match_count, 1);

      run(2, 4, 20, 0, 0);
      chk("t2_count", match_count, 1);

      run(1, 4, 12, 0, 0);
      chk("thresh_equal_count", match_count, 1);
      run(1, 4, 11, 0, 0);
      chk("thresh_below_count", match_count, 0);

      run(3, 4, 255, 10, 0);
      chk("stall_observed", stall_cycles >= 9, 1);
      chk("tie_first_slave", last_s, 1);
      chk("tie_hd", last_hd, 7);
      chk("stall_count", match_count, 3);

      run(3, 0, 255, 0, 0);
      chk("no_slave_core_en", en_total, 0);
      chk("no_slave_count", match_count, 0);
      run(0, 4, 255, 0, 0);
      chk("no_main_count", match_count, 0);

      build_expect(4, 8, 255);
      sweep_ns = 8;
      @(posedge clk); #1;
      start = 1'b1; num_main = 4; num_slave = 8; hd_thresh = 255;
      @(posedge clk); #1;
      start = 1'b0;
      waited = 0;
      while (!slave_rd && waited < 50) begin @(posedge clk); #1; waited++; end
      chk("sweep_reached", slave_rd, 1);
      repeat (3) @(posedge clk);
      #1;
      clear = 1'b1;
      @(posedge clk); #1;
      chk("clear_strobes", {main_rd, slave_rd, core_clear, core_en, out_valid, busy, done}, 0);
      chk("clear_addrs", {main_addr, slave_addr, match_count}, 0);
      clear = 1'b0;
      exp_q.delete();
      run(4, 8, 60, 0, 0);
      chk("after_clear_count", match_count, 4);
      chk("after_clear_last_slave", last_s, 5);

      run(2, 4, 255, 0, 1);
      chk("dup_start_count", match_count, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end
endmodule
